// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Fetch-stage branch predictor: a direct-mapped BTB with one 2-bit saturating
//   counter per entry. The BTB is looked up on F_pc every cycle, the prediction is
//   carried through D to E, and the table trains on the outcome resolved in E.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   F_pc              fetch PC
//   F_pred_taken      predict taken for F_pc (combinational)
//   F_pred_target     predicted target, meaningful only when F_pred_taken=1
//   stall, flush      pipeline stall (D holds, E bubbles) / E-stage redirect (D, E bubble)
//   E_pred_valid      BTB hit recorded for the E-stage instruction
//   E_pred_taken      taken prediction recorded for the E-stage instruction
//   E_is_branch       E-stage instruction is a conditional branch
//   E_branch_taken    resolved branch condition
//   E_pc, E_target    PC and resolved taken target of the E-stage branch
//   E_mispredict      resolved direction disagrees with the E-stage prediction
//   br_count          resolved branches since reset (wraps)
//   mispred_count     mispredicted branches since reset (wraps)

module branch_target_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] F_pc,
  output logic        F_pred_taken,
  output logic [31:0] F_pred_target,
  input  logic        stall,
  input  logic        flush,
  output logic        E_pred_valid,
  output logic        E_pred_taken,
  input  logic        E_is_branch,
  input  logic        E_branch_taken,
  input  logic [31:0] E_pc,
  input  logic [31:0] E_target,
  output logic        E_mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Fetch lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  always_comb begin
    f_idx         = F_pc[IDX_W+1:2];
    f_tag         = F_pc[31:IDX_W+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    F_pred_taken  = f_hit & ctr_q[f_idx][1];
    F_pred_target = target_q[f_idx];
  end

  // Prediction pipeline F -> D -> E
  logic d_hit_q, d_taken_q, d_hit_d, d_taken_d;
  logic e_valid_q, e_taken_q, e_valid_d, e_taken_d;

  always_comb begin
    d_hit_d   = d_hit_q;
    d_taken_d = d_taken_q;
    if (flush) begin
      d_hit_d   = 1'b0;
      d_taken_d = 1'b0;
    end else if (!stall) begin
      d_hit_d   = f_hit;
      d_taken_d = F_pred_taken;
    end
    // E bubbles on both stall and flush, mirroring the controller.
    e_valid_d = 1'b0;
    e_taken_d = 1'b0;
    if (!stall && !flush) begin
      e_valid_d = d_hit_q;
      e_taken_d = d_taken_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_hit_q   <= 1'b0;
      d_taken_q <= 1'b0;
      e_valid_q <= 1'b0;
      e_taken_q <= 1'b0;
    end else begin
      d_hit_q   <= d_hit_d;
      d_taken_q <= d_taken_d;
      e_valid_q <= e_valid_d;
      e_taken_q <= e_taken_d;
    end
  end

  assign E_pred_valid = e_valid_q;
  assign E_pred_taken = e_taken_q;
  assign E_mispredict = E_is_branch & (E_branch_taken ^ (e_valid_q & e_taken_q));

  // Training: at most one entry written per cycle, selected by E_pc
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             tbl_we;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  always_comb begin
    e_idx     = E_pc[IDX_W+1:2];
    e_tag     = E_pc[31:IDX_W+2];
    e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    tbl_we    = 1'b0;
    wr_target = target_q[e_idx];
    wr_ctr    = ctr_q[e_idx];
    if (E_is_branch) begin
      if (e_hit) begin
        tbl_we = 1'b1;
        if (E_branch_taken) begin
          wr_target = E_target;
          if (ctr_q[e_idx] != 2'b11) wr_ctr = ctr_q[e_idx] + 2'b01;
        end else begin
          if (ctr_q[e_idx] != 2'b00) wr_ctr = ctr_q[e_idx] - 2'b01;
        end
      end else if (E_branch_taken) begin
        // Allocate (or evict an alias) as weakly taken
        tbl_we    = 1'b1;
        wr_target = E_target;
        wr_ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (tbl_we) begin
      valid_q[e_idx]  <= 1'b1;
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= wr_target;
      ctr_q[e_idx]    <= wr_ctr;
    end
  end

  // Statistics counters
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q + {31'b0, E_is_branch};
    mispred_count_d = mispred_count_q + {31'b0, E_mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a vector table for lookup, training
// and prediction-pipeline alignment, then hand sequences for stall, flush,
// reset during training and counter wrap.

module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] F_pc;
  logic        F_pred_taken;
  logic [31:0] F_pred_target;
  logic        stall, flush;
  logic        E_pred_valid, E_pred_taken;
  logic        E_is_branch, E_branch_taken;
  logic [31:0] E_pc, E_target;
  logic        E_mispredict;
  logic [31:0] br_count, mispred_count;

  int errors = 0;
  int checks = 0;

  branch_target_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .F_pc           (F_pc),
    .F_pred_taken   (F_pred_taken),
    .F_pred_target  (F_pred_target),
    .stall          (stall),
    .flush          (flush),
    .E_pred_valid   (E_pred_valid),
    .E_pred_taken   (E_pred_taken),
    .E_is_branch    (E_is_branch),
    .E_branch_taken (E_branch_taken),
    .E_pc           (E_pc),
    .E_target       (E_target),
    .E_mispredict   (E_mispredict),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f_pc;
    logic        br;
    logic        tk;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic        x_ft;
    logic [31:0] x_tgt;
    logic        x_ev;
    logic        x_et;
    logic        x_mp;
    logic [31:0] x_br;
    logic [31:0] x_mis;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // f_pc, br, tk, e_pc, e_tgt, x_ft, x_tgt, x_ev, x_et, x_mp, x_br, x_mis
    vec[0]  = '{32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 0, 0, 0};
    vec[1]  = '{32'h200, 1, 1, 32'h100, 32'h080, 0, 32'h000, 0, 0, 1, 0, 0};
    vec[2]  = '{32'h100, 0, 0, 32'h000, 32'h000, 1, 32'h080, 0, 0, 0, 1, 1};
    vec[3]  = '{32'h300, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 0, 1, 1};
    vec[4]  = '{32'h100, 1, 0, 32'h100, 32'h000, 1, 32'h080, 1, 1, 1, 1, 1};
    vec[5]  = '{32'h100, 1, 0, 32'h100, 32'h000, 0, 32'h000, 0, 0, 0, 2, 2};
    vec[6]  = '{32'h104, 0, 0, 32'h000, 32'h000, 0, 32'h000, 1, 1, 0, 3, 2};
    vec[7]  = '{32'h104, 1, 0, 32'h100, 32'h000, 0, 32'h000, 1, 0, 0, 3, 2};
    vec[8]  = '{32'h100, 1, 1, 32'h140, 32'h400, 0, 32'h000, 0, 0, 1, 4, 2};
    vec[9]  = '{32'h100, 0, 0, 32'h000, 32'h000, 0, 32'h000, 0, 0, 0, 5, 3};
    vec[10] = '{32'h140, 0, 0, 32'h000, 32'h000, 1, 32'h400, 1, 0, 0, 5, 3};
    vec[11] = '{32'h140, 1, 1, 32'h140, 32'h404, 1, 32'h400, 0, 0, 1, 5, 3};
    vec[12] = '{32'h140, 1, 1, 32'h140, 32'h404, 1, 32'h404, 1, 1, 0, 6, 4};
    vec[13] = '{32'h180, 1, 0, 32'h180, 32'h000, 0, 32'h000, 1, 1, 1, 7, 4};
    vec[14] = '{32'h180, 0, 0, 32'h000, 32'h000, 0, 32'h000, 1, 1, 0, 8, 5};
    vec[15] = '{32'h140, 0, 0, 32'h000, 32'h000, 1, 32'h404, 0, 0, 0, 8, 5};

    rst = 1'b1; F_pc = 32'h100; stall = 1'b0; flush = 1'b0;
    E_is_branch = 1'b0; E_branch_taken = 1'b0; E_pc = '0; E_target = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_f_taken", {31'b0, F_pred_taken}, 0);
    chk("rst_f_target", F_pred_target, 0);
    chk("rst_e_valid", {31'b0, E_pred_valid}, 0);
    chk("rst_e_taken", {31'b0, E_pred_taken}, 0);
    chk("rst_mispredict", {31'b0, E_mispredict}, 0);
    chk("rst_br_count", br_count, 0);
    chk("rst_mispred_count", mispred_count, 0);

    for (int i = 0; i < 16; i++) begin
      F_pc           = vec[i].f_pc;
      E_is_branch    = vec[i].br;
      E_branch_taken = vec[i].tk;
      E_pc           = vec[i].e_pc;
      E_target       = vec[i].e_tgt;
      #1;
      chk($sformatf("v%0d_f_taken", i), {31'b0, F_pred_taken}, {31'b0, vec[i].x_ft});
      if (vec[i].x_ft) chk($sformatf("v%0d_f_target", i), F_pred_target, vec[i].x_tgt);
      chk($sformatf("v%0d_e_valid", i), {31'b0, E_pred_valid}, {31'b0, vec[i].x_ev});
      chk($sformatf("v%0d_e_taken", i), {31'b0, E_pred_taken}, {31'b0, vec[i].x_et});
      chk($sformatf("v%0d_mispredict", i), {31'b0, E_mispredict}, {31'b0, vec[i].x_mp});
      chk($sformatf("v%0d_br_count", i), br_count, vec[i].x_br);
      chk($sformatf("v%0d_mispred_count", i), mispred_count, vec[i].x_mis);
      tick();
    end
    E_is_branch = 1'b0; E_branch_taken = 1'b0;

    // Stall with a hit (0x140) held in D
    F_pc = 32'h180; stall = 1'b1;
    tick();
    chk("stall_c1_e_valid", {31'b0, E_pred_valid}, 0);
    tick();
    chk("stall_c2_e_valid", {31'b0, E_pred_valid}, 0);
    stall = 1'b0;
    tick();
    chk("unstall_e_valid", {31'b0, E_pred_valid}, 1);
    chk("unstall_e_taken", {31'b0, E_pred_taken}, 1);

    // Flush with hits in D and E; a branch trains in the same cycle
    F_pc = 32'h140;
    tick();
    tick();
    chk("preflush_e_valid", {31'b0, E_pred_valid}, 1);
    flush = 1'b1; E_is_branch = 1'b1; E_branch_taken = 1'b1;
    E_pc = 32'h104; E_target = 32'h500;
    #1;
    chk("flush_mispredict", {31'b0, E_mispredict}, 0);
    tick();
    flush = 1'b0; E_is_branch = 1'b0; E_branch_taken = 1'b0; F_pc = 32'h180;
    #1;
    chk("flush_c1_e_valid", {31'b0, E_pred_valid}, 0);
    tick();
    chk("flush_c2_e_valid", {31'b0, E_pred_valid}, 0);
    F_pc = 32'h104;
    #1;
    chk("flush_train_taken", {31'b0, F_pred_taken}, 1);
    chk("flush_train_target", F_pred_target, 32'h500);
    chk("flush_br_count", br_count, 9);
    chk("flush_mispred_count", mispred_count, 5);

    // Reset asserted while a branch trains
    rst = 1'b1; E_is_branch = 1'b1; E_branch_taken = 1'b1;
    E_pc = 32'h180; E_target = 32'h600; F_pc = 32'h180;
    tick();
    rst = 1'b0; E_is_branch = 1'b0; E_branch_taken = 1'b0;
    #1;
    chk("rst_train_taken", {31'b0, F_pred_taken}, 0);
    chk("rst_train_target", F_pred_target, 0);
    F_pc = 32'h140;
    #1;
    chk("rst_old_entry_taken", {31'b0, F_pred_taken}, 0);
    chk("rst2_br_count", br_count, 0);
    chk("rst2_mispred_count", mispred_count, 0);
    chk("rst2_e_valid", {31'b0, E_pred_valid}, 0);

    // Branch counter wrap from all-ones
    force dut.br_count_q = 32'hFFFF_FFFF;
    E_is_branch = 1'b1;
    #1;
    chk("wrap_next_br_count", dut.br_count_d, 0);
    release dut.br_count_q;
    E_is_branch = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
